snake_body_mem_scheduler: RTL and testbench

// - Owns the single-port snake-body RAM, a 64-deep circular buffer of {x,y} segments.
// - Time-shares one RAM slot per cycle between three requesters:
//   VGA segment queries, game-logic body updates (init/move) and the collision scanner.
// - Sits between snake_food_manager's control logic and snake_vga_renderer.
// - Tracks head pointer and length; maps logical index (0 = head) to physical address.

---
 rtl/snake_pkg.sv | 23 ++
 rtl/snake_slot_arbiter.sv | 27 ++
 rtl/snake_body_mem_scheduler.sv | 229 ++++++++++++++++++++++
 tb/tb_snake_body_mem_scheduler.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/snake_pkg.sv
// Shared types and constants for the snake body memory scheduler.
package snake_pkg;

  localparam int SNAKE_ADDR_W = 6;
  localparam int SNAKE_DEPTH  = 2 ** SNAKE_ADDR_W;
  localparam int INIT_LEN     = 3;

  typedef enum logic [1:0] {
    OP_INIT      = 2'b00,
    OP_MOVE      = 2'b01,
    OP_MOVE_GROW = 2'b10,
    OP_RSVD      = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_INIT       = 3'd1,
    ST_MOVE       = 3'd2,
    ST_SCAN       = 3'd3,
    ST_SCAN_FLUSH = 3'd4
  } state_e;

endpackage

// File: rtl/snake_slot_arbiter.sv
// Grants the next RAM slot to VGA unless a pending body op has already waited
// through STARVE_MAX consecutive VGA grants.
module snake_slot_arbiter #(
  parameter int STARVE_MAX = 15
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic vga_req_i,
  input  logic op_pending_i,
  output logic vga_grant_o
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);

  logic [CNT_W-1:0] starve_q, starve_d;

  always_comb begin
    vga_grant_o = vga_req_i && !(op_pending_i && (starve_q == CNT_W'(STARVE_MAX)));
    starve_d    = (vga_grant_o && op_pending_i) ? starve_q + CNT_W'(1) : '0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) starve_q <= '0;
    else       starve_q <= starve_d;
  end

endmodule

// File: rtl/snake_body_mem_scheduler.sv
// Single-port snake body RAM owner: a circular buffer addressed from the head,
// shared slot-by-slot between VGA queries, body updates and the collision scan.
module snake_body_mem_scheduler
  import snake_pkg::*;
#(
  parameter int X_BITS     = 6,
  parameter int Y_BITS     = 6,
  parameter int ADDR_W     = SNAKE_ADDR_W,
  parameter int LEN_W      = 7,
  parameter int STARVE_MAX = 15
) (
  input  logic                       sys_clk,
  input  logic                       sys_reset,
  input  logic                       vga_req_in,
  input  logic [ADDR_W-1:0]          vga_idx_in,
  output logic [X_BITS-1:0]          vga_x_out,
  output logic [Y_BITS-1:0]          vga_y_out,
  output logic                       vga_valid_out,
  output logic                       vga_ack_out,
  input  logic                       cmd_valid_in,
  input  logic [1:0]                 cmd_op_in,
  input  logic [X_BITS-1:0]          head_x_in,
  input  logic [Y_BITS-1:0]          head_y_in,
  output logic                       cmd_ready_out,
  output logic                       cmd_done_out,
  input  logic                       scan_start_in,
  input  logic [X_BITS-1:0]          scan_x_in,
  input  logic [Y_BITS-1:0]          scan_y_in,
  output logic                       scan_ready_out,
  output logic                       scan_done_out,
  output logic                       scan_hit_out,
  output logic [LEN_W-1:0]           length_out,
  output logic [ADDR_W-1:0]          ram_addr_out,
  output logic                       ram_we_out,
  output logic [X_BITS+Y_BITS-1:0]   ram_wdata_out,
  input  logic [X_BITS+Y_BITS-1:0]   ram_rdata_in
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int W     = X_BITS + Y_BITS;

  state_e              state_q, state_d;
  op_e                 op_q, op_d;
  logic [ADDR_W-1:0]   head_ptr_q, head_ptr_d;
  logic [LEN_W-1:0]    length_q, length_d;
  logic [X_BITS-1:0]   hx_q, hx_d;
  logic [Y_BITS-1:0]   hy_q, hy_d;
  logic [1:0]          seg_q, seg_d;
  logic [ADDR_W-1:0]   scan_idx_q, scan_idx_d;
  logic [W-1:0]        probe_q, probe_d;
  logic                scan_rd_q, scan_rd_d;
  logic                hit_q, hit_d;
  logic                cmd_done_q, cmd_done_d;
  logic                scan_done_q, scan_done_d;
  logic                scan_hit_q, scan_hit_d;

  logic                vga_grant, vga_slot_q, vga_req_q, vga_inrange_q;
  logic                vga_ack_q, vga_valid_q;
  logic [ADDR_W-1:0]   vga_addr_q;
  logic [W-1:0]        vga_data_q;

  logic                op_pending, op_slot, op_we;
  logic [ADDR_W-1:0]   op_addr;
  logic [W-1:0]        op_wdata;

  assign op_pending = (state_q == ST_INIT) || (state_q == ST_MOVE) || (state_q == ST_SCAN);
  // A grant decided this cycle owns the RAM next cycle, so ops use slots VGA was not granted.
  assign op_slot    = !vga_slot_q;

  snake_slot_arbiter #(.STARVE_MAX(STARVE_MAX)) u_arb (
    .clk_i        (sys_clk),
    .rst_i        (sys_reset),
    .vga_req_i    (vga_req_in),
    .op_pending_i (op_pending),
    .vga_grant_o  (vga_grant)
  );

  always_comb begin
    state_d        = state_q;
    op_d           = op_q;
    head_ptr_d     = head_ptr_q;
    length_d       = length_q;
    hx_d           = hx_q;
    hy_d           = hy_q;
    seg_d          = seg_q;
    scan_idx_d     = scan_idx_q;
    probe_d        = probe_q;
    scan_rd_d      = 1'b0;
    hit_d          = hit_q | (scan_rd_q && (ram_rdata_in == probe_q));
    cmd_done_d     = 1'b0;
    scan_done_d    = 1'b0;
    scan_hit_d     = 1'b0;
    cmd_ready_out  = 1'b0;
    scan_ready_out = 1'b0;
    op_we          = 1'b0;
    op_addr        = '0;
    op_wdata       = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid_in) begin
          cmd_ready_out = 1'b1;
          op_d          = op_e'(cmd_op_in);
          hx_d          = head_x_in;
          hy_d          = head_y_in;
          seg_d         = '0;
          case (op_e'(cmd_op_in))
            OP_INIT:               state_d = ST_INIT;
            OP_MOVE, OP_MOVE_GROW: state_d = ST_MOVE;
            default:               state_d = ST_IDLE;
          endcase
        end else if (scan_start_in) begin
          scan_ready_out = 1'b1;
          probe_d        = {scan_x_in, scan_y_in};
          hit_d          = 1'b0;
          scan_idx_d     = ADDR_W'(1);
          if (length_q <= LEN_W'(1)) scan_done_d = 1'b1;
          else                       state_d     = ST_SCAN;
        end
      end
      ST_INIT: begin
        if (op_slot) begin
          op_we    = 1'b1;
          op_addr  = ADDR_W'(seg_q);
          op_wdata = {hx_q - X_BITS'(seg_q), hy_q};
          seg_d    = seg_q + 2'd1;
          if (seg_q == 2'(INIT_LEN - 1)) begin
            head_ptr_d = '0;
            length_d   = LEN_W'(INIT_LEN);
            cmd_done_d = 1'b1;
            state_d    = ST_IDLE;
          end
        end
      end
      ST_MOVE: begin
        if (op_slot) begin
          op_we      = 1'b1;
          op_addr    = head_ptr_q - ADDR_W'(1);
          op_wdata   = {hx_q, hy_q};
          head_ptr_d = op_addr;
          if ((op_q == OP_MOVE_GROW) && (length_q != LEN_W'(DEPTH)))
            length_d = length_q + LEN_W'(1);
          cmd_done_d = 1'b1;
          state_d    = ST_IDLE;
        end
      end
      ST_SCAN: begin
        if (op_slot) begin
          op_addr    = head_ptr_q + scan_idx_q;
          scan_rd_d  = 1'b1;
          scan_idx_d = scan_idx_q + ADDR_W'(1);
          if (LEN_W'(scan_idx_q) == length_q - LEN_W'(1)) state_d = ST_SCAN_FLUSH;
        end
      end
      ST_SCAN_FLUSH: begin
        scan_done_d = 1'b1;
        scan_hit_d  = hit_d;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or posedge sys_reset) begin
    if (sys_reset) begin
      state_q     <= ST_IDLE;
      op_q        <= OP_INIT;
      head_ptr_q  <= '0;
      length_q    <= '0;
      hx_q        <= '0;
      hy_q        <= '0;
      seg_q       <= '0;
      scan_idx_q  <= '0;
      probe_q     <= '0;
      scan_rd_q   <= 1'b0;
      hit_q       <= 1'b0;
      cmd_done_q  <= 1'b0;
      scan_done_q <= 1'b0;
      scan_hit_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      head_ptr_q  <= head_ptr_d;
      length_q    <= length_d;
      hx_q        <= hx_d;
      hy_q        <= hy_d;
      seg_q       <= seg_d;
      scan_idx_q  <= scan_idx_d;
      probe_q     <= probe_d;
      scan_rd_q   <= scan_rd_d;
      hit_q       <= hit_d;
      cmd_done_q  <= cmd_done_d;
      scan_done_q <= scan_done_d;
      scan_hit_q  <= scan_hit_d;
    end
  end

  // VGA pipe: address/range captured at request, RAM read next cycle, ack the cycle after.
  always_ff @(posedge sys_clk or posedge sys_reset) begin
    if (sys_reset) begin
      vga_slot_q    <= 1'b0;
      vga_req_q     <= 1'b0;
      vga_inrange_q <= 1'b0;
      vga_addr_q    <= '0;
      vga_ack_q     <= 1'b0;
      vga_valid_q   <= 1'b0;
      vga_data_q    <= '0;
    end else begin
      vga_slot_q    <= vga_grant;
      vga_req_q     <= vga_req_in;
      vga_inrange_q <= LEN_W'(vga_idx_in) < length_q;
      vga_addr_q    <= head_ptr_q + vga_idx_in;
      vga_ack_q     <= vga_req_q;
      vga_valid_q   <= vga_slot_q && vga_inrange_q;
      if (vga_valid_q) vga_data_q <= ram_rdata_in;
    end
  end

  assign {vga_x_out, vga_y_out} = vga_valid_q ? ram_rdata_in : vga_data_q;
  assign vga_ack_out   = vga_ack_q;
  assign vga_valid_out = vga_valid_q;
  assign cmd_done_out  = cmd_done_q;
  assign scan_done_out = scan_done_q;
  assign scan_hit_out  = scan_hit_q;
  assign length_out    = length_q;
  assign ram_addr_out  = vga_slot_q ? vga_addr_q : op_addr;
  assign ram_we_out    = op_we;
  assign ram_wdata_out = op_wdata;

endmodule

// File: tb/tb_snake_body_mem_scheduler.sv
// Directed bench for the snake body RAM scheduler: table-driven VGA/scan vectors
// plus hand-written sequences for moves, starvation, growth saturation and reset.
module tb_snake_body_mem_scheduler;

  typedef struct {
    bit         isScan;
    logic [5:0] a;
    logic [5:0] b;
    logic       expFlag;
    bit         chkData;
    logic [5:0] expX;
    logic [5:0] expY;
  } vec_t;

  logic        sys_clk = 1'b0;
  logic        sys_reset;
  logic        vga_req_in;
  logic [5:0]  vga_idx_in;
  logic [5:0]  vga_x_out, vga_y_out;
  logic        vga_valid_out, vga_ack_out;
  logic        cmd_valid_in;
  logic [1:0]  cmd_op_in;
  logic [5:0]  head_x_in, head_y_in;
  logic        cmd_ready_out, cmd_done_out;
  logic        scan_start_in;
  logic [5:0]  scan_x_in, scan_y_in;
  logic        scan_ready_out, scan_done_out, scan_hit_out;
  logic [6:0]  length_out;
  logic [5:0]  ram_addr_out;
  logic        ram_we_out;
  logic [11:0] ram_wdata_out;
  logic [11:0] ramRdata = '0;
  logic [11:0] mem [64] = '{default: '0};

  int passCount  = 0;
  int failCount  = 0;
  int totalCount = 0;

  always #5 sys_clk = ~sys_clk;

  snake_body_mem_scheduler #(
    .X_BITS(6), .Y_BITS(6), .ADDR_W(6), .LEN_W(7), .STARVE_MAX(15)
  ) dut (
    .sys_clk(sys_clk), .sys_reset(sys_reset),
    .vga_req_in(vga_req_in), .vga_idx_in(vga_idx_in),
    .vga_x_out(vga_x_out), .vga_y_out(vga_y_out),
    .vga_valid_out(vga_valid_out), .vga_ack_out(vga_ack_out),
    .cmd_valid_in(cmd_valid_in), .cmd_op_in(cmd_op_in),
    .head_x_in(head_x_in), .head_y_in(head_y_in),
    .cmd_ready_out(cmd_ready_out), .cmd_done_out(cmd_done_out),
    .scan_start_in(scan_start_in), .scan_x_in(scan_x_in), .scan_y_in(scan_y_in),
    .scan_ready_out(scan_ready_out), .scan_done_out(scan_done_out),
    .scan_hit_out(scan_hit_out), .length_out(length_out),
    .ram_addr_out(ram_addr_out), .ram_we_out(ram_we_out),
    .ram_wdata_out(ram_wdata_out), .ram_rdata_in(ramRdata)
  );

  // Single-port RAM model with one cycle of read latency.
  always @(posedge sys_clk) begin
    if (ram_we_out) mem[ram_addr_out] <= ram_wdata_out;
    ramRdata <= mem[ram_addr_out];
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got no end of test, expected finish before 2ms");
    $fatal(1, "[TB] simulation hung");
  end

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    totalCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end else begin
      passCount++;
    end
  endtask

  task automatic recordTimeout(input string name);
    totalCount++;
    failCount++;
    $display("[TB] FAIL %s: got timeout, expected handshake", name);
  endtask

  // Returns cycles from accept to cmd_done_out, or -1 if none within maxWait.
  task automatic sendCmd(input logic [1:0] op, input logic [5:0] x, input logic [5:0] y,
                         input int maxWait, output int lat);
    int n;
    cmd_valid_in = 1'b1; cmd_op_in = op; head_x_in = x; head_y_in = y;
    #1;
    n = 0;
    while (!cmd_ready_out && n < 100) begin tick(); #1; n++; end
    if (!cmd_ready_out) recordTimeout("cmdAccept");
    tick();
    cmd_valid_in = 1'b0;
    #1;
    lat = 1;
    while (!cmd_done_out && lat < maxWait) begin tick(); #1; lat++; end
    if (!cmd_done_out) lat = -1;
  endtask

  task automatic doScan(input logic [5:0] x, input logic [5:0] y, output logic hit, output int lat);
    int n;
    scan_start_in = 1'b1; scan_x_in = x; scan_y_in = y;
    #1;
    n = 0;
    while (!scan_ready_out && n < 100) begin tick(); #1; n++; end
    if (!scan_ready_out) recordTimeout("scanAccept");
    tick();
    scan_start_in = 1'b0;
    #1;
    lat = 1;
    while (!scan_done_out && lat < 300) begin tick(); #1; lat++; end
    hit = scan_hit_out;
    if (!scan_done_out) lat = -1;
  endtask

  task automatic vgaQuery(input logic [5:0] idx, output logic ack, output logic valid,
                          output logic [5:0] x, output logic [5:0] y);
    vga_req_in = 1'b1; vga_idx_in = idx;
    tick();
    vga_req_in = 1'b0;
    tick();
    #1;
    ack = vga_ack_out; valid = vga_valid_out; x = vga_x_out; y = vga_y_out;
  endtask

  task automatic applyStimulus(input int i, input vec_t v);
    logic ack, valid, hit;
    logic [5:0] rx, ry;
    int lat;
    if (v.isScan) begin
      doScan(v.a, v.b, hit, lat);
      checkOutput($sformatf("vec%0dScanHit", i), hit, v.expFlag);
      checkOutput($sformatf("vec%0dScanLat", i), lat, 4);
    end else begin
      vgaQuery(v.a, ack, valid, rx, ry);
      checkOutput($sformatf("vec%0dVgaAck", i), ack, 1);
      checkOutput($sformatf("vec%0dVgaValid", i), valid, v.expFlag);
      if (v.chkData) begin
        checkOutput($sformatf("vec%0dVgaX", i), rx, v.expX);
        checkOutput($sformatf("vec%0dVgaY", i), ry, v.expY);
      end
    end
  endtask

  initial begin : mainSeq
    vec_t vecs [8];
    logic ack, valid, hit;
    logic [5:0] rx, ry;
    int lat, weK, weAddr, starvedAcks, starvedK, doneK, doneSeen;

    vecs[0] = '{1'b0, 6'd0,  6'd0,  1'b1, 1'b1, 6'd10, 6'd5};
    vecs[1] = '{1'b0, 6'd1,  6'd0,  1'b1, 1'b1, 6'd9,  6'd5};
    vecs[2] = '{1'b0, 6'd2,  6'd0,  1'b1, 1'b1, 6'd8,  6'd5};
    vecs[3] = '{1'b0, 6'd3,  6'd0,  1'b0, 1'b0, 6'd0,  6'd0};
    vecs[4] = '{1'b0, 6'd63, 6'd0,  1'b0, 1'b0, 6'd0,  6'd0};
    vecs[5] = '{1'b1, 6'd9,  6'd5,  1'b1, 1'b0, 6'd0,  6'd0};
    vecs[6] = '{1'b1, 6'd10, 6'd5,  1'b0, 1'b0, 6'd0,  6'd0};
    vecs[7] = '{1'b1, 6'd20, 6'd20, 1'b0, 1'b0, 6'd0,  6'd0};

    sys_reset = 1'b1;
    vga_req_in = 1'b0; vga_idx_in = '0;
    cmd_valid_in = 1'b0; cmd_op_in = '0; head_x_in = '0; head_y_in = '0;
    scan_start_in = 1'b0; scan_x_in = '0; scan_y_in = '0;
    repeat (3) tick();
    checkOutput("rstLength", length_out, 0);
    checkOutput("rstRamWe", ram_we_out, 0);
    checkOutput("rstVgaAck", {vga_ack_out, vga_valid_out}, 0);
    checkOutput("rstPulses", {cmd_done_out, scan_done_out, scan_hit_out, cmd_ready_out}, 0);
    sys_reset = 1'b0;
    tick();
    checkOutput("idleRamAddr", ram_addr_out, 0);

    // With an empty body the scan completes right after accept and cannot hit.
    doScan(6'd0, 6'd0, hit, lat);
    checkOutput("emptyScanLat", lat, 1);
    checkOutput("emptyScanHit", hit, 0);

    sendCmd(2'b00, 6'd10, 6'd5, 50, lat);
    checkOutput("initLat", lat, 4);
    checkOutput("initLength", length_out, 3);
    checkOutput("initRam0", mem[0], {6'd10, 6'd5});
    checkOutput("initRam1", mem[1], {6'd9, 6'd5});
    checkOutput("initRam2", mem[2], {6'd8, 6'd5});
    tick(); #1;
    checkOutput("initDonePulse", cmd_done_out, 0);

    for (int i = 0; i < 8; i++) applyStimulus(i, vecs[i]);

    for (int i = 1; i <= 5; i++) begin
      sendCmd(2'b01, 6'(10 + i), 6'd5, 50, lat);
      checkOutput($sformatf("move%0dLat", i), lat, 2);
    end
    checkOutput("moveLength", length_out, 3);
    checkOutput("moveRam59", mem[59], {6'd15, 6'd5});
    vgaQuery(6'd0, ack, valid, rx, ry);
    checkOutput("moveVgaHead", {valid, rx, ry}, {1'b1, 6'd15, 6'd5});
    vgaQuery(6'd2, ack, valid, rx, ry);
    checkOutput("moveVgaIdx2", {valid, rx, ry}, {1'b1, 6'd13, 6'd5});

    sendCmd(2'b11, 6'd1, 6'd1, 10, lat);
    checkOutput("rsvdNoDone", lat, -1);
    checkOutput("rsvdLength", length_out, 3);

    // VGA hammers the slot while a MOVE waits; the op must break through once.
    vga_req_in = 1'b1; vga_idx_in = 6'd0;
    cmd_valid_in = 1'b1; cmd_op_in = 2'b01; head_x_in = 6'd16; head_y_in = 6'd5;
    #1;
    checkOutput("starveReady", cmd_ready_out, 1);
    tick();
    cmd_valid_in = 1'b0;
    weK = -1; weAddr = -1; starvedAcks = 0; starvedK = -1; doneK = -1;
    for (int k = 1; k <= 24; k++) begin
      #1;
      if (ram_we_out && weK < 0) begin weK = k; weAddr = int'(ram_addr_out); end
      if (vga_ack_out && !vga_valid_out) begin starvedAcks++; starvedK = k; end
      if (cmd_done_out && doneK < 0) doneK = k;
      tick();
    end
    vga_req_in = 1'b0;
    repeat (3) tick();
    checkOutput("starveWriteCycle", weK, 17);
    checkOutput("starveWriteAddr", weAddr, 58);
    checkOutput("starveAckCount", starvedAcks, 1);
    checkOutput("starveAckCycle", starvedK, 18);
    checkOutput("starveDoneCycle", doneK, 18);
    checkOutput("starveRam58", mem[58], {6'd16, 6'd5});

    sendCmd(2'b00, 6'd1, 6'd2, 50, lat);
    checkOutput("init2Lat", lat, 4);
    vgaQuery(6'd2, ack, valid, rx, ry);
    checkOutput("initWrapX", {valid, rx, ry}, {1'b1, 6'd63, 6'd2});
    for (int k = 1; k <= 61; k++) begin
      sendCmd(2'b10, 6'(k), 6'd7, 50, lat);
      checkOutput($sformatf("grow%0dLat", k), lat, 2);
    end
    checkOutput("growLengthFull", length_out, 64);
    sendCmd(2'b10, 6'd62, 6'd7, 50, lat);
    checkOutput("growSatLength", length_out, 64);
    vgaQuery(6'd0, ack, valid, rx, ry);
    checkOutput("growHead", {valid, rx, ry}, {1'b1, 6'd62, 6'd7});
    vgaQuery(6'd1, ack, valid, rx, ry);
    checkOutput("growIdx1", {valid, rx, ry}, {1'b1, 6'd61, 6'd7});
    vgaQuery(6'd62, ack, valid, rx, ry);
    checkOutput("growIdx62", {valid, rx, ry}, {1'b1, 6'd1, 6'd2});
    vgaQuery(6'd63, ack, valid, rx, ry);
    checkOutput("growTail", {valid, rx, ry}, {1'b1, 6'd0, 6'd2});
    checkOutput("growNoX", $isunknown({vga_x_out, vga_y_out, length_out, ram_addr_out,
                                       ram_we_out, ram_wdata_out, cmd_done_out}), 0);

    // Reset in the middle of a long scan must abort it silently.
    scan_start_in = 1'b1; scan_x_in = 6'd0; scan_y_in = 6'd0;
    #1;
    checkOutput("abortScanReady", scan_ready_out, 1);
    tick();
    scan_start_in = 1'b0;
    repeat (5) tick();
    sys_reset = 1'b1;
    #1;
    checkOutput("abortLength", length_out, 0);
    tick();
    sys_reset = 1'b0;
    doneSeen = 0;
    for (int k = 0; k < 80; k++) begin
      #1;
      if (scan_done_out) doneSeen++;
      tick();
    end
    checkOutput("abortNoDone", doneSeen, 0);

    sendCmd(2'b00, 6'd10, 6'd5, 50, lat);
    checkOutput("reinitLat", lat, 4);
    checkOutput("reinitLength", length_out, 3);
    checkOutput("reinitRam", {mem[0], mem[1], mem[2]},
                {6'd10, 6'd5, 6'd9, 6'd5, 6'd8, 6'd5});
    vgaQuery(6'd0, ack, valid, rx, ry);
    checkOutput("reinitVgaHead", {ack, valid, rx, ry}, {1'b1, 1'b1, 6'd10, 6'd5});

    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule
